tcp_rcv_engine: RTL and testbench

Parametrised TCP receive engine, the successor to the fixed 4-bit receiver used with the sender model. It accepts segments over a valid/ready handshake and uses modular sequence arithmetic. It tracks buffer occupancy, which is drained by a user read port. It issues coalesced, handshaken acknowledgements that carry `rcv_nxt` and the advertised window.

---
 rtl/tcp_rcv_engine.sv | 143 ++++++++++++++
 tb/tb_tcp_rcv_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tcp_rcv_engine.sv
// tcp_rcv_engine: parametrised TCP receive engine.
// Segments arrive on a valid/ready handshake and are checked with modular
// sequence arithmetic. Buffer occupancy is drained by a user read port.
// Acknowledgements are coalesced and carry rcv_nxt and the advertised window.
// Optional feature macro: TCP_RCV_TRIM_EN, which accepts partially duplicate
// segments by trimming the already-received prefix.
module tcp_rcv_engine #(
    parameter int unsigned SEQ_W     = 4,
    parameter int unsigned BUF_DEPTH = 8,
    parameter int unsigned INIT_SEQ  = 0,
    parameter int unsigned CNT_W     = 8,
    localparam int unsigned LEN_W    = $clog2(BUF_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seg_val,
    output logic             seg_rdy,
    input  logic [SEQ_W-1:0] seg_seq,
    input  logic [LEN_W-1:0] seg_len,
    output logic             usr_rd_valid,
    input  logic             usr_rd_ready,
    output logic             ack_valid,
    input  logic             ack_ready,
    output logic [SEQ_W-1:0] ack_seq,
    output logic [LEN_W-1:0] ack_wnd,
    output logic [SEQ_W-1:0] rcv_nxt,
    output logic [LEN_W-1:0] rcv_wnd,
    output logic [CNT_W-1:0] drop_cnt
);

    // Comparison width wide enough for both offsets and lengths.
    localparam int unsigned CW = ((SEQ_W > LEN_W) ? SEQ_W : LEN_W) + 1;

    typedef enum logic [1:0] {
        ACK_IDLE      = 2'd0,
        ACK_SEND      = 2'd1,
        ACK_SEND_PEND = 2'd2
    } ack_state_t;

    ack_state_t       ack_st, ack_nxt;
    logic [LEN_W-1:0] occ;

    logic [SEQ_W-1:0] off;
    logic [CW-1:0]    off_x, len_x, wnd_x, new_x;
    logic [LEN_W-1:0] acc;
    logic             ahead, old, seg_fire, rd_fire, drop, win_upd, ack_event;
    logic [SEQ_W-1:0] rcv_nxt_next;
    logic [LEN_W-1:0] occ_next, wnd_next;
    logic             latch;

    // Engine is ready whenever reset is not held.
    assign seg_rdy = ~reset;

    // Segment classification, accepted length and post-update values.
    always_comb begin
        off          = rcv_nxt - seg_seq;
        off_x        = CW'(off);
        len_x        = CW'(seg_len);
        wnd_x        = CW'(rcv_wnd);
        ahead        = off[SEQ_W-1];
        old          = ~ahead && (off_x >= len_x);
        new_x        = '0;
        if (!ahead && !old) begin
`ifdef TCP_RCV_TRIM_EN
            new_x = len_x - off_x;
`else
            new_x = (off == '0) ? len_x : '0;
`endif
        end
        acc          = '0;
        seg_fire     = seg_val && seg_rdy && (seg_len != '0);
        if (seg_fire) begin
            acc = (new_x < wnd_x) ? LEN_W'(new_x) : rcv_wnd;
        end
        drop         = seg_fire && (acc == '0);
        rd_fire      = usr_rd_valid && usr_rd_ready;
        win_upd      = rd_fire && (occ == LEN_W'(BUF_DEPTH));
        ack_event    = seg_fire || win_upd;
        rcv_nxt_next = rcv_nxt + SEQ_W'(acc);
        occ_next     = occ + acc - LEN_W'(rd_fire);
        wnd_next     = rcv_wnd - acc + LEN_W'(rd_fire);
    end

    // Ack FSM next state; latch selects a fresh snapshot of rcv_nxt/rcv_wnd.
    always_comb begin
        ack_nxt = ack_st;
        latch   = 1'b0;
        case (ack_st)
            ACK_IDLE: begin
                if (ack_event) begin
                    ack_nxt = ACK_SEND;
                    latch   = 1'b1;
                end
            end
            ACK_SEND: begin
                if (ack_ready && ack_event) begin
                    latch = 1'b1;
                end else if (ack_ready) begin
                    ack_nxt = ACK_IDLE;
                end else if (ack_event) begin
                    ack_nxt = ACK_SEND_PEND;
                end
            end
            ACK_SEND_PEND: begin
                if (ack_ready) begin
                    ack_nxt = ACK_SEND;
                    latch   = 1'b1;
                end
            end
            default: ack_nxt = ACK_IDLE;
        endcase
    end

    // State and output registers; reset overrides every coincident event.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_st       <= ACK_IDLE;
            occ          <= '0;
            rcv_nxt      <= SEQ_W'(INIT_SEQ);
            rcv_wnd      <= LEN_W'(BUF_DEPTH);
            usr_rd_valid <= 1'b0;
            drop_cnt     <= '0;
            ack_valid    <= 1'b0;
            ack_seq      <= SEQ_W'(INIT_SEQ);
            ack_wnd      <= LEN_W'(BUF_DEPTH);
        end else begin
            ack_st       <= ack_nxt;
            occ          <= occ_next;
            rcv_nxt      <= rcv_nxt_next;
            rcv_wnd      <= wnd_next;
            usr_rd_valid <= (occ_next != '0);
            ack_valid    <= (ack_nxt != ACK_IDLE);
            if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (latch) begin
                ack_seq <= rcv_nxt_next;
                ack_wnd <= wnd_next;
            end
        end
    end

endmodule

// File: tb/tb_tcp_rcv_engine.sv
// Directed self-checking bench for tcp_rcv_engine with default parameters.
// Expected values are hand-derived from the sequence arithmetic.
module tb_tcp_rcv_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       seg_val;
    logic       seg_rdy;
    logic [3:0] seg_seq;
    logic [3:0] seg_len;
    logic       usr_rd_valid;
    logic       usr_rd_ready;
    logic       ack_valid;
    logic       ack_ready;
    logic [3:0] ack_seq;
    logic [3:0] ack_wnd;
    logic [3:0] rcv_nxt;
    logic [3:0] rcv_wnd;
    logic [7:0] drop_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    tcp_rcv_engine dut (
        .clk          (clk),
        .reset        (reset),
        .seg_val      (seg_val),
        .seg_rdy      (seg_rdy),
        .seg_seq      (seg_seq),
        .seg_len      (seg_len),
        .usr_rd_valid (usr_rd_valid),
        .usr_rd_ready (usr_rd_ready),
        .ack_valid    (ack_valid),
        .ack_ready    (ack_ready),
        .ack_seq      (ack_seq),
        .ack_wnd      (ack_wnd),
        .rcv_nxt      (rcv_nxt),
        .rcv_wnd      (rcv_wnd),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] seq, input logic [3:0] len);
        seg_val = 1'b1;
        seg_seq = seq;
        seg_len = len;
        cyc();
        seg_val = 1'b0;
    endtask

    task automatic rd(input int n);
        usr_rd_ready = 1'b1;
        cyc(n);
        usr_rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; seg_val = 1'b0; seg_seq = '0; seg_len = '0;
        usr_rd_ready = 1'b0; ack_ready = 1'b1;
        cyc(2);
        chk("rst_seg_rdy", seg_rdy, 0);
        chk("rst_nxt", rcv_nxt, 0);
        chk("rst_wnd", rcv_wnd, 8);
        chk("rst_ack_valid", ack_valid, 0);
        chk("rst_ack_seq", ack_seq, 0);
        chk("rst_ack_wnd", ack_wnd, 8);
        chk("rst_rd_valid", usr_rd_valid, 0);
        chk("rst_drop", drop_cnt, 0);
        reset = 1'b0;
        #1;
        chk("seg_rdy", seg_rdy, 1);

        // Zero-length segment is ignored.
        send(4'd0, 4'd0);
        chk("len0_ack", ack_valid, 0);
        chk("len0_nxt", rcv_nxt, 0);

        // Basic in-order segment.
        ack_ready = 1'b0;
        send(4'd0, 4'd3);
        chk("b_nxt", rcv_nxt, 3);
        chk("b_wnd", rcv_wnd, 5);
        chk("b_ack_valid", ack_valid, 1);
        chk("b_ack_seq", ack_seq, 3);
        chk("b_ack_wnd", ack_wnd, 5);
        chk("b_rd_valid", usr_rd_valid, 1);
        ack_ready = 1'b1;
        cyc();
        chk("b_ack_done", ack_valid, 0);

        // Window clipping, then zero-window drop with duplicate ack.
        do_reset();
        send(4'd0, 4'd10);
        chk("clip_nxt", rcv_nxt, 8);
        chk("clip_wnd", rcv_wnd, 0);
        send(4'd8, 4'd2);
        chk("zw_drop", drop_cnt, 1);
        chk("zw_nxt", rcv_nxt, 8);
        chk("zw_ack_valid", ack_valid, 1);
        chk("zw_ack_seq", ack_seq, 8);
        chk("zw_ack_wnd", ack_wnd, 0);

        // Read from a full buffer produces a window update.
        rd(1);
        chk("wu_wnd", rcv_wnd, 1);
        chk("wu_ack_valid", ack_valid, 1);
        chk("wu_ack_wnd", ack_wnd, 1);
        chk("wu_ack_seq", ack_seq, 8);
        cyc();
        chk("wu_ack_done", ack_valid, 0);

        // Sequence wrap and ahead segment.
        do_reset();
        send(4'd0, 4'd7);
        rd(7);
        send(4'd7, 4'd7);
        rd(7);
        chk("pre_wrap_nxt", rcv_nxt, 14);
        chk("pre_wrap_wnd", rcv_wnd, 8);
        send(4'd14, 4'd4);
        chk("wrap_nxt", rcv_nxt, 2);
        chk("wrap_wnd", rcv_wnd, 4);
        send(4'd4, 4'd1);
        chk("ahead_drop", drop_cnt, 1);
        chk("ahead_nxt", rcv_nxt, 2);

        // Partially duplicate segment.
        rd(4);
        send(4'd2, 4'd3);
        rd(3);
        chk("ovl_pre_nxt", rcv_nxt, 5);
        send(4'd3, 4'd4);
`ifdef TCP_RCV_TRIM_EN
        chk("ovl_nxt", rcv_nxt, 7);
        chk("ovl_drop", drop_cnt, 1);
`else
        chk("ovl_nxt", rcv_nxt, 5);
        chk("ovl_drop", drop_cnt, 2);
`endif
        // Old segment (fully duplicate) is dropped.
        send(4'd1, 4'd2);
`ifdef TCP_RCV_TRIM_EN
        chk("old_drop", drop_cnt, 2);
`else
        chk("old_drop", drop_cnt, 3);
`endif

        // Coalescing while the sender stalls.
        do_reset();
        ack_ready = 1'b0;
        send(4'd0, 4'd1);
        send(4'd1, 4'd1);
        send(4'd2, 4'd1);
        chk("co_nxt", rcv_nxt, 3);
        chk("co_valid", ack_valid, 1);
        chk("co_held_seq", ack_seq, 1);
        chk("co_held_wnd", ack_wnd, 7);
        ack_ready = 1'b1;
        cyc();
        ack_ready = 1'b0;
        chk("co2_valid", ack_valid, 1);
        chk("co2_seq", ack_seq, 3);
        chk("co2_wnd", ack_wnd, 5);
        cyc();
        chk("co2_stable", ack_seq, 3);
        ack_ready = 1'b1;
        cyc();
        chk("co_idle", ack_valid, 0);

        // Reset abandons an in-flight ack.
        ack_ready = 1'b0;
        send(4'd3, 4'd1);
        chk("ra_valid", ack_valid, 1);
        reset = 1'b1;
        cyc();
        chk("ra_ack_valid", ack_valid, 0);
        chk("ra_nxt", rcv_nxt, 0);
        chk("ra_ack_seq", ack_seq, 0);
        reset = 1'b0;
        ack_ready = 1'b1;

        // Drop counter saturates.
        for (int i = 0; i < 260; i++) send(4'd8, 4'd1);
        chk("sat_drop", drop_cnt, 255);
        chk("sat_nxt", rcv_nxt, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
